// File: rtl/block_mac_2x2.sv
// block_mac_2x2: 2x2 block multiply-accumulate responder, C_acc += A x B.
//
// A single shared multiplier runs the eight partial products in sequence. Its
// output is registered, so each product is added one edge after it is formed.
// The C block is published in one step and held until the next completion.
//
// Ports:
//   clk                  clock, all state on the rising edge
//   rst                  asynchronous active-low reset
//   start_mac            operation request, sampled only while idle
//   clear_acc            with an accepted start_mac: zero the accumulators first
//   a_11..a_22           A block operands, captured on acceptance
//   b_11..b_22           B block operands, captured on acceptance
//   busy                 high from the acceptance edge to the done_mac edge
//   done_mac             single-cycle completion pulse, c_* valid with it
//   c_11..c_22           registered accumulated result block
module block_mac_2x2 #(
    parameter int unsigned data_w     = 32,
    parameter int unsigned extra_wait = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_mac,
    input  logic              clear_acc,
    input  logic [data_w-1:0] a_11,
    input  logic [data_w-1:0] a_12,
    input  logic [data_w-1:0] a_21,
    input  logic [data_w-1:0] a_22,
    input  logic [data_w-1:0] b_11,
    input  logic [data_w-1:0] b_12,
    input  logic [data_w-1:0] b_21,
    input  logic [data_w-1:0] b_22,
    output logic              busy,
    output logic              done_mac,
    output logic [data_w-1:0] c_11,
    output logic [data_w-1:0] c_12,
    output logic [data_w-1:0] c_21,
    output logic [data_w-1:0] c_22
);

    typedef enum logic [1:0] {StIdle, StMul, StWait, StDone} state_e;

    state_e state_q, state_d;

    // Word index 0..3 = x_11, x_12, x_21, x_22 for operands, accumulators and results.
    logic [3:0][data_w-1:0] op_a_q, op_a_d;
    logic [3:0][data_w-1:0] op_b_q, op_b_d;
    logic [3:0][data_w-1:0] acc_q, acc_d;
    logic [3:0][data_w-1:0] c_q, c_d;

    logic [data_w-1:0] prod_q, prod_d;
    logic [1:0]        prod_dst_q, prod_dst_d;
    logic              prod_vld_q, prod_vld_d;

    logic [3:0] step_q, step_d;
    logic [4:0] wait_q, wait_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    logic [1:0]        a_idx, b_idx;
    logic [data_w-1:0] mul_p;

    // Step order 0..7 walks a11*b11, a12*b21, a11*b12, a12*b22, a21*b11, a22*b21,
    // a21*b12, a22*b22; the destination accumulator is step[2:1].
    assign a_idx = {step_q[2], step_q[0]};
    assign b_idx = {step_q[0], step_q[1]};

    // Low data_w bits of a two's complement product equal those of the unsigned
    // product, so a plain truncating multiply gives the signed result.
    assign mul_p = op_a_q[a_idx] * op_b_q[b_idx];

    always_comb begin
        state_d    = state_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        acc_d      = acc_q;
        c_d        = c_q;
        prod_d     = prod_q;
        prod_dst_d = prod_dst_q;
        prod_vld_d = 1'b0;
        step_d     = step_q;
        wait_d     = wait_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        // Second pipeline stage: fold the registered product into its accumulator.
        if (prod_vld_q) begin
            acc_d[prod_dst_q] = acc_q[prod_dst_q] + prod_q;
        end

        unique case (state_q)
            StIdle: begin
                if (start_mac) begin
                    op_a_d  = {a_22, a_21, a_12, a_11};
                    op_b_d  = {b_22, b_21, b_12, b_11};
                    busy_d  = 1'b1;
                    step_d  = 4'd0;
                    state_d = StMul;
                    if (clear_acc) begin
                        acc_d = '0;
                    end
                end
            end
            StMul: begin
                if (step_q < 4'd8) begin
                    prod_d     = mul_p;
                    prod_dst_d = step_q[2:1];
                    prod_vld_d = 1'b1;
                    step_d     = step_q + 4'd1;
                end else begin
                    // Step 8 only drains the last product out of the pipeline.
                    wait_d  = 5'(extra_wait);
                    state_d = (extra_wait > 0) ? StWait : StDone;
                end
            end
            StWait: begin
                if (wait_q <= 5'd1) begin
                    state_d = StDone;
                end else begin
                    wait_d = wait_q - 5'd1;
                end
            end
            StDone: begin
                c_d     = acc_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            op_a_q     <= '0;
            op_b_q     <= '0;
            acc_q      <= '0;
            c_q        <= '0;
            prod_q     <= '0;
            prod_dst_q <= '0;
            prod_vld_q <= 1'b0;
            step_q     <= '0;
            wait_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            acc_q      <= acc_d;
            c_q        <= c_d;
            prod_q     <= prod_d;
            prod_dst_q <= prod_dst_d;
            prod_vld_q <= prod_vld_d;
            step_q     <= step_d;
            wait_q     <= wait_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done_mac = done_q;
    assign c_11     = c_q[0];
    assign c_12     = c_q[1];
    assign c_21     = c_q[2];
    assign c_22     = c_q[3];

endmodule

// File: tb/tb_block_mac_2x2.sv
// Self-checking bench for block_mac_2x2. A reference model of the accumulators
// predicts each C block when an operation is started; the prediction is queued
// and compared when done_mac fires. A second instance with extra_wait=3 checks
// the stretched latency.
module tb_block_mac_2x2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start_mac = 1'b0;
    logic        start3 = 1'b0;
    logic        clear_acc = 1'b0;
    logic [31:0] a_11 = '0, a_12 = '0, a_21 = '0, a_22 = '0;
    logic [31:0] b_11 = '0, b_12 = '0, b_21 = '0, b_22 = '0;
    logic        busy, done_mac, busy3, done3;
    logic [31:0] c_11, c_12, c_21, c_22;
    logic [31:0] c3_11, c3_12, c3_21, c3_22;

    int errors = 0;
    int checks = 0;

    logic [3:0][31:0] macc = '0;
    logic [127:0]     exp_q[$];

    always #5 clk = ~clk;

    block_mac_2x2 #(.data_w(32), .extra_wait(0)) u_dut (
        .clk(clk), .rst(rst), .start_mac(start_mac), .clear_acc(clear_acc),
        .a_11(a_11), .a_12(a_12), .a_21(a_21), .a_22(a_22),
        .b_11(b_11), .b_12(b_12), .b_21(b_21), .b_22(b_22),
        .busy(busy), .done_mac(done_mac),
        .c_11(c_11), .c_12(c_12), .c_21(c_21), .c_22(c_22)
    );

    block_mac_2x2 #(.data_w(32), .extra_wait(3)) u_dut3 (
        .clk(clk), .rst(rst), .start_mac(start3), .clear_acc(clear_acc),
        .a_11(a_11), .a_12(a_12), .a_21(a_21), .a_22(a_22),
        .b_11(b_11), .b_12(b_12), .b_21(b_21), .b_22(b_22),
        .busy(busy3), .done_mac(done3),
        .c_11(c3_11), .c_12(c3_12), .c_21(c3_21), .c_22(c3_22)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        start_mac = 1'b0;
        start3 = 1'b0;
        tick();
        tick();
        @(negedge clk);
        rst = 1'b1;
        macc = '0;
        exp_q.delete();
        tick();
    endtask

    task automatic set_ops(input logic [3:0][31:0] a, input logic [3:0][31:0] b,
                           input logic clr);
        a_11 = a[0]; a_12 = a[1]; a_21 = a[2]; a_22 = a[3];
        b_11 = b[0]; b_12 = b[1]; b_21 = b[2]; b_22 = b[3];
        clear_acc = clr;
    endtask

    // Model of one accepted operation; queues the C block it should publish.
    task automatic push_expected(input logic [3:0][31:0] a, input logic [3:0][31:0] b,
                                 input logic clr);
        logic [31:0] p0, p1, p2, p3, p4, p5, p6, p7;
        if (clr) macc = '0;
        p0 = a[0] * b[0]; p1 = a[1] * b[2];
        p2 = a[0] * b[1]; p3 = a[1] * b[3];
        p4 = a[2] * b[0]; p5 = a[3] * b[2];
        p6 = a[2] * b[1]; p7 = a[3] * b[3];
        macc[0] = macc[0] + p0 + p1;
        macc[1] = macc[1] + p2 + p3;
        macc[2] = macc[2] + p4 + p5;
        macc[3] = macc[3] + p6 + p7;
        exp_q.push_back({macc[0], macc[1], macc[2], macc[3]});
    endtask

    // Starts one op on u_dut and returns edges from acceptance to done_mac (-1 on timeout).
    task automatic do_op(input logic [3:0][31:0] a, input logic [3:0][31:0] b,
                         input logic clr, output int lat);
        set_ops(a, b, clr);
        push_expected(a, b, clr);
        start_mac = 1'b1;
        tick();
        start_mac = 1'b0;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (done_mac) begin
                lat = k;
                break;
            end
        end
    endtask

    // Scoreboard: every done_mac must match the oldest queued prediction.
    always begin
        @(posedge clk);
        #1;
        if (done_mac) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_done: got done_mac=1 required no pending op");
            end else begin
                logic [127:0] e;
                e = exp_q.pop_front();
                if ({c_11, c_12, c_21, c_22} !== e) begin
                    errors++;
                    $display("FAIL sb_result: got %h %h %h %h required %h %h %h %h",
                             c_11, c_12, c_21, c_22, e[127:96], e[95:64], e[63:32], e[31:0]);
                end
            end
        end
    end

    task automatic test_reset();
        rst = 1'b0;
        #2;
        checks++;
        if ({busy, done_mac, c_11, c_12, c_21, c_22} !== '0) begin
            errors++;
            $display("FAIL reset_state: got busy=%b done=%b c=%h %h %h %h required all 0",
                     busy, done_mac, c_11, c_12, c_21, c_22);
        end
        do_reset();
    endtask

    task automatic test_basic();
        logic [3:0][31:0] a, b;
        int lat;
        bit  busy_bad;
        a = {32'd4, 32'd3, 32'd2, 32'd1};
        b = {32'd8, 32'd7, 32'd6, 32'd5};
        set_ops(a, b, 1'b1);
        push_expected(a, b, 1'b1);
        start_mac = 1'b1;
        tick();
        start_mac = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_busy_accept: got %b required 1", busy);
        end
        lat = -1;
        busy_bad = 0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (done_mac) begin
                lat = k;
                break;
            end
            if (busy !== 1'b1) busy_bad = 1;
        end
        checks++;
        if (busy_bad) begin
            errors++;
            $display("FAIL basic_busy_hold: got busy low before done required high");
        end
        checks++;
        if (lat != 10) begin
            errors++;
            $display("FAIL basic_latency: got %0d required 10", lat);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_busy_done: got %b required 0", busy);
        end
        checks++;
        if ({c_11, c_12, c_21, c_22} !== {32'd19, 32'd22, 32'd43, 32'd50}) begin
            errors++;
            $display("FAIL basic_result: got %0d %0d %0d %0d required 19 22 43 50",
                     c_11, c_12, c_21, c_22);
        end
        tick();
        tick();
        checks++;
        if (done_mac !== 1'b0 || {c_11, c_12, c_21, c_22} !== {32'd19, 32'd22, 32'd43, 32'd50})
        begin
            errors++;
            $display("FAIL basic_pulse_hold: got done=%b c11=%0d required done=0 c11=19",
                     done_mac, c_11);
        end
    endtask

    task automatic test_accumulate();
        int lat;
        do_op({32'd4, 32'd3, 32'd2, 32'd1}, {32'd8, 32'd7, 32'd6, 32'd5}, 1'b0, lat);
        checks++;
        if (lat != 10 || {c_11, c_12, c_21, c_22} !== {32'd38, 32'd44, 32'd86, 32'd100}) begin
            errors++;
            $display("FAIL accum_result: got lat=%0d c=%0d %0d %0d %0d required 10 38 44 86 100",
                     lat, c_11, c_12, c_21, c_22);
        end
        do_op({32'd1, 32'd0, 32'd0, 32'd1}, {32'd9, 32'd9, 32'd9, 32'd9}, 1'b1, lat);
        checks++;
        if ({c_11, c_12, c_21, c_22} !== {32'd9, 32'd9, 32'd9, 32'd9}) begin
            errors++;
            $display("FAIL accum_clear: got %0d %0d %0d %0d required 9 9 9 9",
                     c_11, c_12, c_21, c_22);
        end
    endtask

    task automatic test_signed_wrap();
        int lat;
        do_op({32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF}, {32'd0, 32'd0, 32'd0, 32'd3}, 1'b1, lat);
        checks++;
        if ({c_11, c_12, c_21, c_22} !== {32'hFFFF_FFFD, 32'd0, 32'd0, 32'd0}) begin
            errors++;
            $display("FAIL signed_neg: got %h %h %h %h required fffffffd 0 0 0",
                     c_11, c_12, c_21, c_22);
        end
        do_op({32'd0, 32'd0, 32'd0, 32'h0001_0000}, {32'd0, 32'd0, 32'd0, 32'h0001_0000},
              1'b1, lat);
        checks++;
        if ({c_11, c_12, c_21, c_22} !== 128'd0) begin
            errors++;
            $display("FAIL signed_trunc: got %h %h %h %h required 0 0 0 0",
                     c_11, c_12, c_21, c_22);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0][31:0] a, b;
        int  ndone;
        bool_t: begin end
        ndone = 0;
        start_mac = 1'b1;
        for (int k = 0; k <= 32; k++) begin
            for (int i = 0; i < 4; i++) begin
                a[i] = $urandom;
                b[i] = $urandom;
            end
            if (k == 0 || k == 11 || k == 22) begin
                set_ops(a, b, k == 0);
                push_expected(a, b, k == 0);
            end else begin
                set_ops(a, b, 1'($urandom_range(1, 0)));
            end
            tick();
            if (done_mac) ndone++;
            checks++;
            if (done_mac !== (k == 10 || k == 21 || k == 32)) begin
                errors++;
                $display("FAIL b2b_done_k%0d: got %b required %b", k, done_mac,
                         (k == 10 || k == 21 || k == 32));
            end
            checks++;
            if (busy !== !(k == 10 || k == 21 || k == 32)) begin
                errors++;
                $display("FAIL b2b_busy_k%0d: got %b required %b", k, busy,
                         !(k == 10 || k == 21 || k == 32));
            end
        end
        start_mac = 1'b0;
        tick();
        checks++;
        if (ndone != 3 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_count: got %0d dones busy=%b required 3 busy=0", ndone, busy);
        end
    endtask

    task automatic test_reset_abort();
        logic [3:0][31:0] a, b;
        int  lat;
        bit  seen;
        a = {32'd4, 32'd3, 32'd2, 32'd1};
        b = {32'd8, 32'd7, 32'd6, 32'd5};
        set_ops(a, b, 1'b0);
        start_mac = 1'b1;
        tick();
        start_mac = 1'b0;
        for (int k = 1; k <= 4; k++) tick();
        rst = 1'b0;
        #1;
        checks++;
        if ({busy, done_mac, c_11, c_12, c_21, c_22} !== '0) begin
            errors++;
            $display("FAIL abort_state: got busy=%b done=%b c=%h %h %h %h required all 0",
                     busy, done_mac, c_11, c_12, c_21, c_22);
        end
        @(negedge clk);
        rst = 1'b1;
        macc = '0;
        exp_q.delete();
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (done_mac || busy) seen = 1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL abort_quiet: got done_mac/busy after reset required none");
        end
        // Accumulators must have been cleared by reset: no clear_acc here.
        do_op(a, b, 1'b0, lat);
        checks++;
        if ({c_11, c_12, c_21, c_22} !== {32'd19, 32'd22, 32'd43, 32'd50}) begin
            errors++;
            $display("FAIL abort_acc_zero: got %0d %0d %0d %0d required 19 22 43 50",
                     c_11, c_12, c_21, c_22);
        end
    endtask

    task automatic test_extra_wait();
        logic [3:0][31:0] a, b;
        int lat3;
        do_reset();
        a = {32'd4, 32'd3, 32'd2, 32'd1};
        b = {32'd8, 32'd7, 32'd6, 32'd5};
        set_ops(a, b, 1'b1);
        push_expected(a, b, 1'b1);
        start_mac = 1'b1;
        start3 = 1'b1;
        tick();
        start_mac = 1'b0;
        start3 = 1'b0;
        lat3 = -1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (k == 12) begin
                checks++;
                if (busy3 !== 1'b1) begin
                    errors++;
                    $display("FAIL ew_busy_before: got %b required 1", busy3);
                end
            end
            if (done3) begin
                lat3 = k;
                checks++;
                if (busy3 !== 1'b0) begin
                    errors++;
                    $display("FAIL ew_busy_done: got %b required 0", busy3);
                end
                break;
            end
        end
        checks++;
        if (lat3 != 13) begin
            errors++;
            $display("FAIL ew_latency: got %0d required 13", lat3);
        end
        checks++;
        if ({c3_11, c3_12, c3_21, c3_22} !== {32'd19, 32'd22, 32'd43, 32'd50}) begin
            errors++;
            $display("FAIL ew_result: got %0d %0d %0d %0d required 19 22 43 50",
                     c3_11, c3_12, c3_21, c3_22);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_accumulate();
        test_signed_wrap();
        test_back_to_back();
        test_reset_abort();
        test_extra_wait();
        tick();
        tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: got %0d pending results required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation timeout required completion");
        $fatal(1, "timeout");
    end

endmodule
